// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the I2C controller APB register bank.
// Holds the register address map, STATUS and INT_STAT bit positions,
// the APB access FSM state type and the internal register-select code.
package apb_i2c_pkg;

  localparam logic [7:0] ADDR_TXDATA  = 8'h00;
  localparam logic [7:0] ADDR_RXDATA  = 8'h04;
  localparam logic [7:0] ADDR_CONFIG  = 8'h08;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;
  localparam logic [7:0] ADDR_INTEN   = 8'h14;
  localparam logic [7:0] ADDR_INTSTAT = 8'h18;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_I2C_ERR  = 3;
  localparam int STAT_W        = 4;

  localparam int INT_TX_EMPTY = 0;
  localparam int INT_RX_DATA  = 1;
  localparam int INT_I2C_ERR  = 2;
  localparam int INT_W        = 3;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} apb_state_t;

  typedef enum logic [2:0] {
    SEL_TXDATA, SEL_RXDATA, SEL_CONFIG, SEL_TIMEOUT,
    SEL_STATUS, SEL_INTEN, SEL_INTSTAT, SEL_NONE
  } reg_sel_t;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: edge detectors on the FIFO/core status levels, sticky
// INT_STAT with write-1-to-clear (a same-cycle set beats the clear), and
// the registered IRQ output.
// Ports: PCLK/PRESET clock and sync active-high reset; TX_EMPTY, RX_EMPTY,
// I2C_ERR status levels; int_en enable mask; w1c_valid/w1c_mask clear
// request; int_stat sticky status; IRQ interrupt request.
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             TX_EMPTY,
  input  logic             RX_EMPTY,
  input  logic             I2C_ERR,
  input  logic [INT_W-1:0] int_en,
  input  logic             w1c_valid,
  input  logic [INT_W-1:0] w1c_mask,
  output logic [INT_W-1:0] int_stat,
  output logic             IRQ
);

  logic             tx_empty_p1;
  logic             rx_empty_p1;
  logic             i2c_err_p1;
  logic [INT_W-1:0] set_ev;
  logic [INT_W-1:0] clr;

  always_comb begin
    set_ev               = '0;
    set_ev[INT_TX_EMPTY] = TX_EMPTY & ~tx_empty_p1;
    set_ev[INT_RX_DATA]  = ~RX_EMPTY & rx_empty_p1;
    set_ev[INT_I2C_ERR]  = I2C_ERR & ~i2c_err_p1;
    clr                  = w1c_valid ? w1c_mask : '0;
  end

  // History resets to "FIFOs empty, no error" so a quiet system raises nothing.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_empty_p1 <= 1'b1;
      rx_empty_p1 <= 1'b1;
      i2c_err_p1  <= 1'b0;
      int_stat    <= '0;
      IRQ         <= 1'b0;
    end else begin
      tx_empty_p1 <= TX_EMPTY;
      rx_empty_p1 <= RX_EMPTY;
      i2c_err_p1  <= I2C_ERR;
      int_stat    <= (int_stat & ~clr) | set_ev;
      IRQ         <= |(int_stat & int_en);
    end
  end

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB slave front-end for the I2C controller. Every transfer gets one wait
// state (IDLE decision cycle), RXDATA reads additionally wait RD_LAT cycles
// for the RX FIFO. Illegal accesses answer with PSLVERR and have no effect.
// Ports: APB slave (PCLK, PRESET, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
// PRDATA, PREADY, PSLVERR); TX FIFO push (TX_WR_EN, TX_WDATA, TX_FULL,
// TX_EMPTY); RX FIFO pop (RX_RD_EN, RX_RDATA, RX_EMPTY); core error level
// I2C_ERR; CFG_REG/TMO_REG register outputs; IRQ interrupt request.
module apb_i2c_regbank
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CFG_W  = 14,
  parameter int TMO_W  = 14,
  parameter int RD_LAT = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TX_WR_EN,
  output logic [DATA_W-1:0] TX_WDATA,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  output logic              RX_RD_EN,
  input  logic [DATA_W-1:0] RX_RDATA,
  input  logic              RX_EMPTY,
  input  logic              I2C_ERR,
  output logic [CFG_W-1:0]  CFG_REG,
  output logic [TMO_W-1:0]  TMO_REG,
  output logic              IRQ
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  apb_state_t        state, state_next;
  reg_sel_t          sel, sel_p1;
  logic              wr_p1, err_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [CFG_W-1:0]  cfg;
  logic [TMO_W-1:0]  tmo;
  logic [INT_W-1:0]  int_en, int_stat;
  logic [STAT_W-1:0] status;
  logic [DATA_W-1:0] rd_val;
  logic              access, illegal, rx_pop, commit, w1c_valid;

  function automatic reg_sel_t decode(input logic [ADDR_W-1:0] addr);
    if (addr == ADDR_W'(ADDR_TXDATA))  return SEL_TXDATA;
    if (addr == ADDR_W'(ADDR_RXDATA))  return SEL_RXDATA;
    if (addr == ADDR_W'(ADDR_CONFIG))  return SEL_CONFIG;
    if (addr == ADDR_W'(ADDR_TIMEOUT)) return SEL_TIMEOUT;
    if (addr == ADDR_W'(ADDR_STATUS))  return SEL_STATUS;
    if (addr == ADDR_W'(ADDR_INTEN))   return SEL_INTEN;
    if (addr == ADDR_W'(ADDR_INTSTAT)) return SEL_INTSTAT;
    return SEL_NONE;
  endfunction

  always_comb begin
    sel    = decode(PADDR);
    access = (state == IDLE) & PSEL & PENABLE;

    // FIFO flags only matter here, in the IDLE decision cycle.
    illegal = 1'b0;
    case (sel)
      SEL_TXDATA: illegal = ~PWRITE | TX_FULL;
      SEL_RXDATA: illegal = PWRITE | RX_EMPTY;
      SEL_STATUS: illegal = PWRITE;
      SEL_NONE:   illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
    rx_pop = access & (sel == SEL_RXDATA) & ~illegal;

    status                = '0;
    status[STAT_TX_EMPTY] = TX_EMPTY;
    status[STAT_TX_FULL]  = TX_FULL;
    status[STAT_RX_EMPTY] = RX_EMPTY;
    status[STAT_I2C_ERR]  = I2C_ERR;

    rd_val = '0;
    case (sel)
      SEL_CONFIG:  rd_val = DATA_W'(cfg);
      SEL_TIMEOUT: rd_val = DATA_W'(tmo);
      SEL_STATUS:  rd_val = DATA_W'(status);
      SEL_INTEN:   rd_val = DATA_W'(int_en);
      SEL_INTSTAT: rd_val = DATA_W'(int_stat);
      default:     rd_val = '0;
    endcase

    // Side effects land on the RESP edge, and only if the master is still there.
    commit    = (state == RESP) & PSEL & wr_p1 & ~err_p1;
    w1c_valid = commit & (sel_p1 == SEL_INTSTAT);

    state_next = state;
    case (state)
      IDLE:    if (access) state_next = rx_pop ? RD_WAIT : RESP;
      RD_WAIT: begin
        if (!PSEL)                        state_next = IDLE;
        else if (cnt_p1 == CNT_W'(1))     state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign RX_RD_EN = rx_pop;
  assign TX_WR_EN = commit & (sel_p1 == SEL_TXDATA);
  assign CFG_REG  = cfg;
  assign TMO_REG  = tmo;

  // Access FSM and registered response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      sel_p1   <= SEL_NONE;
      wr_p1    <= 1'b0;
      err_p1   <= 1'b0;
      cnt_p1   <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
      TX_WDATA <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (access) begin
          sel_p1 <= sel;
          wr_p1  <= PWRITE;
          err_p1 <= illegal;
          cnt_p1 <= CNT_W'(RD_LAT);
          if (!rx_pop) begin
            PREADY  <= 1'b1;
            PSLVERR <= illegal;
            PRDATA  <= (illegal | PWRITE) ? '0 : rd_val;
          end
          if (PWRITE && sel == SEL_TXDATA && !illegal) TX_WDATA <= PWDATA;
        end
        RD_WAIT: if (PSEL) begin
          cnt_p1 <= cnt_p1 - CNT_W'(1);
          if (cnt_p1 == CNT_W'(1)) begin
            PREADY  <= 1'b1;
            PSLVERR <= 1'b0;
            PRDATA  <= RX_RDATA;
          end
        end
        RESP: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Software-visible registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cfg    <= '0;
      tmo    <= '0;
      int_en <= '0;
    end else if (commit) begin
      case (sel_p1)
        SEL_CONFIG:  cfg    <= PWDATA[CFG_W-1:0];
        SEL_TIMEOUT: tmo    <= PWDATA[TMO_W-1:0];
        SEL_INTEN:   int_en <= PWDATA[INT_W-1:0];
        default: ;
      endcase
    end
  end

  apb_i2c_irq u_irq (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .TX_EMPTY  (TX_EMPTY),
    .RX_EMPTY  (RX_EMPTY),
    .I2C_ERR   (I2C_ERR),
    .int_en    (int_en),
    .w1c_valid (w1c_valid),
    .w1c_mask  (PWDATA[INT_W-1:0]),
    .int_stat  (int_stat),
    .IRQ       (IRQ)
  );

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Scoreboard bench for apb_i2c_regbank (RD_LAT=3): directed scenarios
// followed by random APB traffic against a behavioural register-map model.
module tb_apb_i2c_regbank;

  localparam int RD_LAT = 3;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, TX_WDATA, RX_RDATA;
  logic        PREADY, PSLVERR, TX_WR_EN, TX_FULL, TX_EMPTY;
  logic        RX_RD_EN, RX_EMPTY, I2C_ERR, IRQ;
  logic [13:0] CFG_REG, TMO_REG;

  apb_i2c_regbank #(.RD_LAT(RD_LAT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .TX_WR_EN(TX_WR_EN),
    .TX_WDATA(TX_WDATA), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_RD_EN(RX_RD_EN), .RX_RDATA(RX_RDATA), .RX_EMPTY(RX_EMPTY),
    .I2C_ERR(I2C_ERR), .CFG_REG(CFG_REG), .TMO_REG(TMO_REG), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          cycles;
    bit          tx;
    logic [31:0] txd;
    int          pops;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [13:0] cfg_m, tmo_m;
  logic [2:0]  inten_m, intstat_m;
  bit          prev_txe, prev_rxe, prev_err;
  logic [31:0] rx_word;
  logic [7:0]  pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Interrupt sources are defined by edges of the levels the bench drives.
  task automatic apply_flags();
    if (TX_EMPTY && !prev_txe) intstat_m[0] = 1'b1;
    if (!RX_EMPTY && prev_rxe) intstat_m[1] = 1'b1;
    if (I2C_ERR && !prev_err)  intstat_m[2] = 1'b1;
    prev_txe = TX_EMPTY;
    prev_rxe = RX_EMPTY;
    prev_err = I2C_ERR;
  endtask

  task automatic model_reset();
    cfg_m = '0; tmo_m = '0; inten_m = '0; intstat_m = '0;
    prev_txe = 1'b1; prev_rxe = 1'b1; prev_err = 1'b0;
    apply_flags();
  endtask

  task automatic set_flags(input bit te, input bit tf, input bit re, input bit er);
    @(posedge PCLK); #1;
    TX_EMPTY = te; TX_FULL = tf; RX_EMPTY = re; I2C_ERR = er;
    apply_flags();
  endtask

  // RX FIFO model: the popped word is valid exactly RD_LAT cycles after the pop.
  initial begin
    pend = '0;
    RX_RDATA = '0;
    forever begin
      @(posedge PCLK);
      pend = {pend[6:0], RX_RD_EN};
      #1;
      RX_RDATA = pend[RD_LAT-1] ? rx_word : ~rx_word;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  initial begin
    int   acc_n, pop_n;
    exp_t e;
    acc_n = 0;
    pop_n = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET === 1'b1) begin
        acc_n = 0;
        pop_n = 0;
      end else begin
        if (PSEL && PENABLE) acc_n++;
        if (RX_RD_EN) pop_n++;
        if (PREADY === 1'b1) begin
          if (expq.size() == 0) begin
            chk("unexpected_pready", 32'(PREADY), 32'd0);
          end else begin
            e = expq.pop_front();
            chk("prdata", PRDATA, e.rdata);
            chk("pslverr", 32'(PSLVERR), 32'(e.err));
            chk("access_cycles", 32'(acc_n), 32'(e.cycles));
            chk("tx_wr_en", 32'(TX_WR_EN), 32'(e.tx));
            if (e.tx) chk("tx_wdata", TX_WDATA, e.txd);
            chk("rx_pops", 32'(pop_n), 32'(e.pops));
          end
          acc_n = 0;
          pop_n = 0;
        end
      end
    end
  end

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit err_rise);
    int n;
    bit got;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    if (err_rise) I2C_ERR = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 32) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) got = 1'b1;
      n++;
    end
    if (!got) begin
      chk("pready_timeout", 32'd0, 32'd1);
      if (expq.size() > 0) void'(expq.pop_back());
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit err_rise);
    exp_t        e;
    bit          legal;
    logic [31:0] rv;
    legal = 1'b1;
    rv    = '0;
    case (a)
      8'h00: legal = wr && !TX_FULL;
      8'h04: begin legal = !wr && !RX_EMPTY; rv = rx_word; end
      8'h08: rv = {18'd0, cfg_m};
      8'h0C: rv = {18'd0, tmo_m};
      8'h10: begin legal = !wr; rv = {28'd0, I2C_ERR, RX_EMPTY, TX_FULL, TX_EMPTY}; end
      8'h14: rv = {29'd0, inten_m};
      8'h18: rv = {29'd0, intstat_m};
      default: legal = 1'b0;
    endcase
    e.rdata  = (legal && !wr) ? rv : 32'd0;
    e.err    = !legal;
    e.cycles = (legal && a == 8'h04) ? 2 + RD_LAT : 2;
    e.tx     = legal && wr && (a == 8'h00);
    e.txd    = d;
    e.pops   = (legal && a == 8'h04) ? 1 : 0;
    expq.push_back(e);
    apb(wr, a, d, err_rise);
    if (legal && wr) begin
      case (a)
        8'h08: cfg_m = d[13:0];
        8'h0C: tmo_m = d[13:0];
        8'h14: inten_m = d[2:0];
        8'h18: intstat_m = intstat_m & ~d[2:0];
        default: ;
      endcase
    end
    if (err_rise) apply_flags();
  endtask

  task automatic check_quiet();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("cfg_reg", 32'(CFG_REG), 32'(cfg_m));
    chk("tmo_reg", 32'(TMO_REG), 32'(tmo_m));
    chk("irq", 32'(IRQ), 32'(|(intstat_m & inten_m)));
  endtask

  initial begin
    logic [7:0] addrs [10];
    logic [7:0] a;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; TX_FULL = 1'b0; TX_EMPTY = 1'b1;
    RX_EMPTY = 1'b1; I2C_ERR = 1'b0; rx_word = 32'h0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_tx_wr_en", 32'(TX_WR_EN), 32'd0);
    chk("rst_rx_rd_en", 32'(RX_RD_EN), 32'd0);
    chk("rst_cfg", 32'(CFG_REG), 32'd0);
    chk("rst_tmo", 32'(TMO_REG), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);

    // CONFIG width truncation and readback
    issue(1'b1, 8'h08, 32'hFFFF_ABCD, 1'b0);
    check_quiet();
    chk("cfg_2bcd", 32'(CFG_REG), 32'h0000_2BCD);
    issue(1'b0, 8'h08, 32'h0, 1'b0);
    issue(1'b1, 8'h0C, 32'h1234_5A5A, 1'b0);
    check_quiet();

    // TX pushes, accepted and refused
    set_flags(1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 8'h00, 32'hDEAD_BEEF, 1'b0);
    set_flags(1'b0, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 8'h00, 32'hCAFE_F00D, 1'b0);

    // RX pop with latency, then refused on empty
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    rx_word = 32'h1234_5678;
    issue(1'b0, 8'h04, 32'h0, 1'b0);
    set_flags(1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 8'h04, 32'h0, 1'b0);
    issue(1'b0, 8'h10, 32'h0, 1'b0);

    // Illegal accesses leave everything untouched
    issue(1'b0, 8'h1C, 32'h0, 1'b0);
    issue(1'b1, 8'h1C, 32'hFFFF_FFFF, 1'b0);
    issue(1'b1, 8'h02, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 8'h0A, 32'h0, 1'b0);
    issue(1'b1, 8'h10, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 8'h00, 32'h0, 1'b0);
    issue(1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0);
    check_quiet();
    issue(1'b0, 8'h18, 32'h0, 1'b0);

    // Interrupt latency and set-beats-clear
    issue(1'b1, 8'h18, 32'h7, 1'b0);
    issue(1'b1, 8'h14, 32'h2, 1'b0);
    check_quiet();
    @(posedge PCLK); #1;
    RX_EMPTY = 1'b0;
    apply_flags();
    @(posedge PCLK); @(negedge PCLK);
    chk("irq_not_yet", 32'(IRQ), 32'd0);
    @(posedge PCLK); @(negedge PCLK);
    chk("irq_one_later", 32'(IRQ), 32'd1);
    issue(1'b0, 8'h18, 32'h0, 1'b0);
    issue(1'b1, 8'h18, 32'h2, 1'b1);
    check_quiet();
    issue(1'b0, 8'h18, 32'h0, 1'b0);

    // Reset while waiting on the RX FIFO
    issue(1'b1, 8'h14, 32'h7, 1'b0);
    check_quiet();
    rx_word = 32'h0BAD_CAFE;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    @(negedge PCLK);
    chk("mid_rst_pready", 32'(PREADY), 32'd0);
    chk("mid_rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("mid_rst_prdata", PRDATA, 32'd0);
    chk("mid_rst_cfg", 32'(CFG_REG), 32'd0);
    chk("mid_rst_tmo", 32'(TMO_REG), 32'd0);
    chk("mid_rst_irq", 32'(IRQ), 32'd0);
    issue(1'b0, 8'h18, 32'h0, 1'b0);
    check_quiet();

    // Random traffic
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h02, 8'h00};
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rx_word = $urandom;
      a = addrs[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      check_quiet();
    end

    repeat (4) @(posedge PCLK);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
